// File: rtl/jtframe_prog_loader.sv
// Buffers ROM download bytes in a 4-deep FIFO and issues them as SDRAM (held until prog_ack) or PROM (single-strobe) writes.
// Latency: ioctl_wr in cycle k -> prog_we/prom_we from cycle k+2; a full FIFO drops the byte unless a pop happens that same cycle.
module jtframe_prog_loader #(
  parameter logic [22:0] PROM_START  = 23'h40_0000,
  parameter int          POST_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [22:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        prog_ack,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  output logic        prom_we,
  output logic        dwnld_busy,
  output logic        overflow
);

  localparam logic [21:0] POST_LOAD = 22'(POST_CYCLES);

  logic [30:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        empty, full, pop, push;
  logic [22:0] head_addr;
  logic [7:0]  head_data;
  logic [21:0] post_cnt;
  logic        dl_last;

  assign empty = (count == 3'd0);
  assign full  = (count == 3'd4);
  // prog_we low at the edge guarantees the mandatory idle cycle after an ack
  assign pop   = !empty && !prog_we;
  assign push  = ioctl_wr && (!full || pop);
  assign {head_addr, head_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ioctl_addr, ioctl_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_we   <= 1'b0;
      prom_we   <= 1'b0;
      prog_addr <= 22'd0;
      prog_data <= 8'd0;
      prog_mask <= 2'b11;
    end else begin
      prom_we <= 1'b0;
      if (prog_we && prog_ack) prog_we <= 1'b0;
      if (pop) begin
        prog_data <= head_data;
        if (head_addr >= PROM_START) begin
          prom_we   <= 1'b1;
          prog_addr <= 22'(head_addr - PROM_START);
          prog_mask <= 2'b11;
        end else begin
          prog_we   <= 1'b1;
          prog_addr <= head_addr[22:1];
          prog_mask <= head_addr[0] ? 2'b01 : 2'b10;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      dl_last  <= 1'b0;
      post_cnt <= 22'd0;
    end else begin
      dl_last <= downloading;
      if (ioctl_wr && full && !pop)         overflow <= 1'b1;
      else if (downloading && !dl_last)     overflow <= 1'b0;
      if (downloading || !empty || prog_we || prom_we) post_cnt <= POST_LOAD;
      else if (post_cnt != 22'd0)                      post_cnt <= post_cnt - 22'd1;
    end
  end

  assign dwnld_busy = downloading || !empty || prog_we || (post_cnt != 22'd0);

endmodule

// File: tb/tb_jtframe_prog_loader.sv
// Randomized and directed bench for jtframe_prog_loader against a queue-based model of the byte stream.
module tb_jtframe_prog_loader;
  localparam int          POST   = 40;
  localparam logic [22:0] PSTART = 23'h40_0000;

  logic        clk, rst, downloading, ioctl_wr, prog_ack;
  logic [22:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we, prom_we, dwnld_busy, overflow;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        prom;
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } wr_t;

  jtframe_prog_loader #(.PROM_START(PSTART), .POST_CYCLES(POST)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_ack(prog_ack), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_we(prog_we), .prom_we(prom_we),
    .dwnld_busy(dwnld_busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic wr_t expect_of(logic [22:0] a, logic [7:0] d);
    wr_t w;
    logic [22:0] off;
    w.data = d;
    if (a >= PSTART) begin
      off    = a - PSTART;
      w.prom = 1'b1;
      w.addr = off[21:0];
      w.mask = 2'b11;
    end else begin
      w.prom = 1'b0;
      w.addr = 22'(a / 2);
      w.mask = (a % 2 == 1) ? 2'b01 : 2'b10;
    end
    return w;
  endfunction

  function automatic logic [22:0] rnd_sdram();
    return 23'($urandom_range(0, 32'h3F_FFFF));
  endfunction

  function automatic logic [22:0] rnd_prom();
    return PSTART + 23'($urandom_range(0, 32'h3F_FFFF));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [22:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; prog_ack = 1'b0;
    ioctl_addr = 23'd0; ioctl_data = 8'd0;
    #3;
    n_cmp++;
    if ({prog_we, prom_we, overflow, dwnld_busy, prog_mask, prog_addr, prog_data} !==
        {4'b0000, 2'b11, 22'd0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_state: got we=%b prom=%b ovf=%b busy=%b mask=%b addr=%h data=%h",
               prog_we, prom_we, overflow, dwnld_busy, prog_mask, prog_addr, prog_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [22:0] a;
    logic [7:0]  d;
    wr_t e;
    downloading = 1'b1; prog_ack = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 23'h00_0005 : rnd_sdram();
      d = (i == 0) ? 8'hA5 : 8'($urandom);
      e = expect_of(a, d);
      send(a, d);
      n_cmp++;
      if (prog_we !== 1'b0) begin
        n_err++; $display("FAIL single_k1_we: got %b want 0", prog_we);
      end
      tick();
      n_cmp++;
      if ({prog_we, prom_we, prog_addr, prog_mask, prog_data} !== {2'b10, e.addr, e.mask, e.data}) begin
        n_err++;
        $display("FAIL single_k2[%0d]: got we=%b prom=%b addr=%h mask=%b data=%h want we=1 addr=%h mask=%b data=%h",
                 i, prog_we, prom_we, prog_addr, prog_mask, prog_data, e.addr, e.mask, e.data);
      end
      tick();
      n_cmp++;
      if (prog_we !== 1'b0) begin
        n_err++; $display("FAIL single_k3_we: got %b want 0", prog_we);
      end
    end
  endtask

  task automatic test_overflow();
    logic [22:0] a [6];
    logic [7:0]  d [6];
    wr_t e;
    int got, extra;
    prog_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a[i] = rnd_sdram(); d[i] = 8'($urandom);
      send(a[i], d[i]);
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_set: got %b want 1", overflow);
    end
    prog_ack = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (prog_we) begin
        e = expect_of(a[got], d[got]);
        n_cmp++;
        if ({prog_addr, prog_mask, prog_data} !== {e.addr, e.mask, e.data}) begin
          n_err++;
          $display("FAIL ovf_order[%0d]: got addr=%h mask=%b data=%h want addr=%h mask=%b data=%h",
                   got, prog_addr, prog_mask, prog_data, e.addr, e.mask, e.data);
        end
        got++;
      end
      tick();
    end
    n_cmp++;
    if (got != 5) begin
      n_err++; $display("FAIL ovf_count: got %0d writes want 5", got);
    end
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      if (prog_we || prom_we) extra++;
      tick();
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++; $display("FAIL ovf_dropped: got %0d extra writes want 0", extra);
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    downloading = 1'b0; tick();
    downloading = 1'b1; tick();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_prom();
    logic [22:0] a;
    logic [7:0]  d;
    wr_t e;
    prog_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 23'h40_0010 : rnd_prom();
      d = 8'($urandom);
      e = expect_of(a, d);
      send(a, d);
      tick();
      n_cmp++;
      if ({prom_we, prog_we, prog_addr, prog_data} !== {2'b10, e.addr, e.data}) begin
        n_err++;
        $display("FAIL prom_pulse[%0d]: got prom=%b we=%b addr=%h data=%h want prom=1 we=0 addr=%h data=%h",
                 i, prom_we, prog_we, prog_addr, prog_data, e.addr, e.data);
      end
      tick();
      n_cmp++;
      if ({prom_we, prog_we} !== 2'b00) begin
        n_err++; $display("FAIL prom_single: got prom=%b we=%b want 0 0", prom_we, prog_we);
      end
    end
  endtask

  task automatic test_push_pop_full();
    wr_t q[$];
    wr_t e;
    logic [22:0] a;
    logic [7:0]  d;
    int extra;
    prog_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = rnd_sdram(); d = 8'($urandom);
      q.push_back(expect_of(a, d));
      send(a, d);
    end
    prog_ack = 1'b1;
    tick();
    void'(q.pop_front());
    prog_ack = 1'b0;
    a = rnd_sdram(); d = 8'($urandom);
    q.push_back(expect_of(a, d));
    send(a, d);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL full_pushpop_ovf: got %b want 0", overflow);
    end
    prog_ack = 1'b1;
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      if (prog_we) begin
        if (q.size() == 0) extra++;
        else begin
          e = q.pop_front();
          n_cmp++;
          if ({prog_addr, prog_mask, prog_data} !== {e.addr, e.mask, e.data}) begin
            n_err++;
            $display("FAIL full_pushpop_order: got addr=%h data=%h want addr=%h data=%h",
                     prog_addr, prog_data, e.addr, e.data);
          end
        end
      end
      tick();
    end
    n_cmp++;
    if (q.size() != 0 || extra != 0) begin
      n_err++; $display("FAIL full_pushpop_count: got %0d missing %0d extra want 0 0", q.size(), extra);
    end
  endtask

  task automatic test_drain();
    wr_t exp_w [3];
    logic [22:0] a;
    logic [7:0]  d;
    int got, fall_t, busy_t;
    logic prev_hs;
    prog_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = rnd_sdram(); d = 8'($urandom);
      exp_w[i] = expect_of(a, d);
      send(a, d);
    end
    downloading = 1'b0;
    got = 0; fall_t = -1; busy_t = -1; prev_hs = 1'b0;
    for (int t = 0; t < POST + 100; t++) begin
      if (prev_hs) begin
        n_cmp++;
        if (prog_we !== 1'b0) begin
          n_err++; $display("FAIL drain_gap: got we=%b want 0 after ack", prog_we);
        end
        fall_t = t;
      end
      if (!dwnld_busy) begin
        busy_t = t;
        break;
      end
      prog_ack = (t % 3 == 2);
      prev_hs = prog_we && prog_ack;
      if (prev_hs && got < 3) begin
        n_cmp++;
        if ({prog_addr, prog_mask, prog_data} !== {exp_w[got].addr, exp_w[got].mask, exp_w[got].data}) begin
          n_err++;
          $display("FAIL drain_order[%0d]: got addr=%h data=%h want addr=%h data=%h",
                   got, prog_addr, prog_data, exp_w[got].addr, exp_w[got].data);
        end
        got++;
      end
      tick();
    end
    n_cmp++;
    if (got != 3) begin
      n_err++; $display("FAIL drain_count: got %0d want 3", got);
    end
    n_cmp++;
    if (busy_t < 0 || fall_t < 0 || busy_t - fall_t != POST) begin
      n_err++; $display("FAIL drain_busy_tail: got %0d cycles want %0d", busy_t - fall_t, POST);
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] a;
    logic [7:0]  d;
    wr_t e;
    int extra;
    prog_ack = 1'b0; downloading = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd_sdram(), 8'($urandom));
    n_cmp++;
    if (prog_we !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: got we=%b want 1", prog_we);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({prog_we, prom_we, overflow, dwnld_busy, prog_mask, prog_addr, prog_data} !==
        {4'b0000, 2'b11, 22'd0, 8'd0}) begin
      n_err++;
      $display("FAIL rstmid_state: got we=%b prom=%b ovf=%b busy=%b mask=%b addr=%h data=%h",
               prog_we, prom_we, overflow, dwnld_busy, prog_mask, prog_addr, prog_data);
    end
    @(posedge clk); #1;
    rst = 1'b0; prog_ack = 1'b1;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      if (prog_we || prom_we || dwnld_busy) extra++;
      tick();
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", extra);
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    a = rnd_sdram(); d = 8'($urandom);
    e = expect_of(a, d);
    send(a, d);
    tick();
    n_cmp++;
    if ({prog_we, prog_addr, prog_data} !== {1'b1, e.addr, e.data}) begin
      n_err++;
      $display("FAIL rst_first_cycle: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
               prog_we, prog_addr, prog_data, e.addr, e.data);
    end
    tick();
  endtask

  task automatic test_random();
    wr_t q[$];
    logic pend, prev_hs;
    logic [21:0] h_addr;
    logic [7:0]  h_data;
    logic [1:0]  h_mask;
    logic [22:0] a;
    logic [7:0]  d;
    downloading = 1'b1; pend = 1'b0; prev_hs = 1'b0;
    h_addr = '0; h_data = '0; h_mask = '0;
    for (int t = 0; t < 700; t++) begin
      if (prev_hs) begin
        n_cmp++;
        if (prog_we !== 1'b0) begin
          n_err++; $display("FAIL rnd_gap: t=%0d got we=%b want 0", t, prog_we);
        end
      end
      if (prom_we) begin
        n_cmp++;
        if (q.size() == 0 || !q[0].prom || q[0].addr !== prog_addr || q[0].data !== prog_data) begin
          n_err++; $display("FAIL rnd_prom: t=%0d got addr=%h data=%h, queue head mismatch", t, prog_addr, prog_data);
        end
        if (q.size() > 0) void'(q.pop_front());
      end
      if (prog_we) begin
        n_cmp++;
        if (pend) begin
          if ({prog_addr, prog_data, prog_mask} !== {h_addr, h_data, h_mask}) begin
            n_err++; $display("FAIL rnd_hold: t=%0d got addr=%h data=%h want addr=%h data=%h",
                              t, prog_addr, prog_data, h_addr, h_data);
          end
        end else if (q.size() == 0 || q[0].prom ||
                     {prog_addr, prog_data, prog_mask} !== {q[0].addr, q[0].data, q[0].mask}) begin
          n_err++; $display("FAIL rnd_sdram: t=%0d got addr=%h data=%h mask=%b, queue head mismatch",
                            t, prog_addr, prog_data, prog_mask);
        end
        h_addr = prog_addr; h_data = prog_data; h_mask = prog_mask;
      end
      prog_ack = ($urandom_range(0, 2) == 0);
      prev_hs = prog_we && prog_ack;
      pend = prog_we && !prog_ack;
      if (prev_hs && q.size() > 0) void'(q.pop_front());
      if (t < 550 && q.size() < 4 && $urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 1) ? rnd_prom() : rnd_sdram();
        d = 8'($urandom);
        q.push_back(expect_of(a, d));
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
      end else begin
        ioctl_wr = 1'b0;
      end
      tick();
    end
    ioctl_wr = 1'b0;
    n_cmp++;
    if (q.size() != 0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL rnd_drained: got %0d pending ovf=%b want 0 0", q.size(), overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_prom();
    test_push_pop_full();
    test_drain();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtframe_prog_loader.md
JTFRAME_PROG_LOADER -- requirements
Module: jtframe_prog_loader

Interface
REQ-001 The block SHALL have parameter PROM_START, default 23'h40_0000: first byte address routed to on-chip PROMs instead of SDRAM.
REQ-002 The block SHALL have parameter POST_CYCLES, default 1024: clock cycles for which dwnld_busy stays high after the last write drains.
REQ-003 clk  in  1  single clock; all logic is on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 downloading  in  1  ROM download in progress.
REQ-006 ioctl_addr  in  23  byte address of the incoming ROM byte.
REQ-007 ioctl_data  in  8  incoming ROM byte.
REQ-008 ioctl_wr  in  1  one-cycle strobe; the byte is valid in the same cycle.
REQ-009 prog_ack  in  1  SDRAM controller has accepted the current prog_we request.
REQ-010 prog_addr  out  22  16-bit word address for SDRAM; for PROM writes it carries the PROM byte offset instead.
REQ-011 prog_data  out  8  byte to write.
REQ-012 prog_mask  out  2  active-low byte-lane enable.
REQ-013 prog_we  out  1  SDRAM write request, held until acknowledged.
REQ-014 prom_we  out  1  one-cycle PROM write strobe.
REQ-015 dwnld_busy  out  1  load pipeline not yet idle.
REQ-016 overflow  out  1  sticky flag: a byte was dropped.

Function
REQ-017 Each ioctl_wr cycle SHALL push {ioctl_addr, ioctl_data} into a 4-entry FIFO; bytes SHALL leave the block in arrival order.
REQ-018 When the FIFO is full and ioctl_wr arrives without a pop in the same cycle, the byte SHALL be dropped and overflow SHALL be set.
REQ-019 A simultaneous push and pop on a full FIFO SHALL NOT set overflow, and the pushed entry SHALL be kept.
REQ-020 SDRAM entries (addr < PROM_START) SHALL drive prog_addr = addr[22:1] and prog_data = data.
REQ-021 For SDRAM entries, prog_mask SHALL be 2'b10 when addr[0]=0 and 2'b01 when addr[0]=1.
REQ-022 PROM entries (addr >= PROM_START) SHALL drive prog_addr = addr - PROM_START, truncated to 22 bits, with prog_data = data.
REQ-023 A PROM entry SHALL pulse prom_we for exactly one cycle, SHALL NOT assert prog_we, and SHALL NOT wait for prog_ack.
REQ-024 Pop/issue SHALL happen at a rising edge where the FIFO is non-empty, prog_we is low and the previous-cycle ack gap is satisfied.
REQ-025 prog_we, prog_addr, prog_data and prog_mask SHALL be registered outputs.
REQ-026 Idle latency: ioctl_wr high in cycle k gives prog_we (or prom_we) high from cycle k+2.
REQ-027 prog_we SHALL stay high, with prog_addr, prog_data and prog_mask stable, until prog_ack is sampled high.
REQ-028 prog_we SHALL fall at the edge where prog_ack is sampled high.
REQ-029 After prog_we falls, there SHALL be at least one low cycle before the next prog_we assertion.
REQ-030 prog_ack while prog_we is low SHALL be ignored.
REQ-031 The 22-bit POST_CYCLES counter SHALL load POST_CYCLES on every cycle with downloading high, FIFO non-empty, prog_we high or prom_we high.
REQ-032 Otherwise the counter SHALL decrement toward 0 and saturate at 0.
REQ-033 dwnld_busy SHALL equal downloading OR FIFO non-empty OR prog_we OR counter != 0.
REQ-034 When downloading falls with FIFO entries pending, those entries SHALL still drain normally.
REQ-035 A rising edge of downloading SHALL clear overflow.
REQ-036 ioctl_wr while downloading is low SHALL still be accepted.

Reset
REQ-037 rst high SHALL asynchronously empty the FIFO and set prog_we=0, prom_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, overflow=0 and counter=0, so dwnld_busy=0 when downloading=0.
REQ-038 Reset asserted mid-request SHALL drop the pending request with no further prog_we.
REQ-039 After reset release, the block SHALL accept ioctl_wr in the first clock cycle.

Verification
REQ-040 Idle; ioctl_wr at k with addr 23'h000005, data 8'hA5; prog_ack tied high -> prog_we high at k+2 with prog_addr 22'h000002, prog_mask 2'b01, prog_data 8'hA5; low at k+3.
REQ-041 Six consecutive ioctl_wr with prog_ack held low, then prog_ack high -> entries 1-5 emerge in order, the 6th is dropped, overflow=1; next downloading rise clears it.
REQ-042 ioctl_wr at addr 23'h400010 -> single prom_we pulse with prog_addr 22'h000010; prog_we stays 0.
REQ-043 downloading falls with 3 entries pending, ack every 3rd cycle -> all 3 written with a gap of at least 1 cycle between them; dwnld_busy falls exactly POST_CYCLES cycles after the last prog_we falls.
REQ-044 rst pulse while prog_we is high and 2 entries are queued -> all outputs at reset values within the reset cycle, with no prog_we after release until a new ioctl_wr.
REQ-045 Push and pop in the same cycle with the FIFO full -> count unchanged and overflow stays 0.
